// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the motor driver: PWM counter width,
// mid-scale duty and the signed speed command type.
package mtr_drv_pkg;

    localparam int PWM_W = 11;
    localparam logic [PWM_W-1:0] PWM_MAX = 11'h7FF;
    localparam logic [PWM_W-1:0] DUTY_MID = 11'h400;

    typedef logic signed [11:0] spd_t;
    typedef logic [PWM_W-1:0] cnt_t;

    // Clamp a signed speed to +/-max_spd and offset it to an unsigned duty.
    function automatic cnt_t spd_to_duty(input spd_t spd, input spd_t max_spd);
        spd_t sat;
        logic [11:0] sum;
        if (spd > max_spd) begin
            sat = max_spd;
        end else if (spd < -max_spd) begin
            sat = -max_spd;
        end else begin
            sat = spd;
        end
        sum = sat + {1'b0, DUTY_MID};
        return sum[PWM_W-1:0];
    endfunction

endpackage

// File: rtl/mtr_drv_pwm_chan.sv
// One half-bridge channel: registered hi/lo gates with dead-time around the
// duty edge and the wrap, plus the blanked window used to qualify over-current.
module pwm_chan
    import mtr_drv_pkg::*;
#(
    parameter int NONOVERLAP = 32,
    parameter int BLANK      = 64
) (
    input  logic clk,
    input  logic rst,
    input  cnt_t cnt,
    input  cnt_t duty,
    input  logic kill,
    output logic hi,
    output logic lo,
    output logic qual_win
);

    localparam int XW = PWM_W + 1;
    localparam logic [XW-1:0] DEAD = XW'(NONOVERLAP);
    localparam logic [XW-1:0] QUAL_START = XW'(NONOVERLAP + BLANK);

    logic [XW-1:0] cnt_x;
    logic [XW-1:0] duty_x;
    logic hi_nxt;
    logic lo_nxt;
    logic win_nxt;

    // One extra bit keeps duty+dead-time from wrapping into the lo window.
    always_comb begin
        cnt_x   = {1'b0, cnt};
        duty_x  = {1'b0, duty};
        hi_nxt  = (cnt_x >= DEAD) && (cnt_x < duty_x);
        lo_nxt  = cnt_x >= (duty_x + DEAD);
        win_nxt = (cnt_x >= QUAL_START) && (cnt_x < duty_x);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi       <= 1'b0;
            lo       <= 1'b0;
            qual_win <= 1'b0;
        end else begin
            hi       <= hi_nxt & ~kill;
            lo       <= lo_nxt & ~kill;
            qual_win <= win_nxt & ~kill;
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Dual-channel dead-time PWM motor driver with per-period duty loading and
// a latched over-current shutdown after consecutive faulty periods.
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int NONOVERLAP = 32,
    parameter int MAX_SPD    = 960,
    parameter int BLANK      = 64,
    parameter int FAULT_LIM  = 4
) (
    input  logic clk,
    input  logic rst,
    input  spd_t lft_spd,
    input  spd_t rght_spd,
    input  logic en,
    input  logic ovr_i,
    output logic lft_hi,
    output logic lft_lo,
    output logic rght_hi,
    output logic rght_lo,
    output logic pwm_synch,
    output logic ovr_flt
);

    localparam spd_t SAT_MAG = spd_t'(MAX_SPD);
    localparam int FC_W = $clog2(FAULT_LIM + 1);
    localparam logic [FC_W-1:0] FC_LIM = FC_W'(FAULT_LIM);

    cnt_t cnt;
    cnt_t lft_duty;
    cnt_t rght_duty;
    cnt_t lft_duty_nxt;
    cnt_t rght_duty_nxt;
    logic cnt_end;
    logic gate_kill;
    logic lft_win;
    logic rght_win;
    logic ovr_qual;
    logic period_faulty;
    logic [FC_W-1:0] fault_cnt;

    assign cnt_end       = (cnt == PWM_MAX);
    assign gate_kill     = ~en | ovr_flt;
    assign lft_duty_nxt  = spd_to_duty(lft_spd, SAT_MAG);
    assign rght_duty_nxt = spd_to_duty(rght_spd, SAT_MAG);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            pwm_synch <= 1'b0;
        end else begin
            cnt       <= cnt + cnt_t'(1);
            pwm_synch <= (cnt == '0);
        end
    end

    // Duty only changes at the wrap so each period sees one consistent value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lft_duty  <= DUTY_MID;
            rght_duty <= DUTY_MID;
        end else if (cnt_end) begin
            lft_duty  <= lft_duty_nxt;
            rght_duty <= rght_duty_nxt;
        end
    end

    pwm_chan #(
        .NONOVERLAP(NONOVERLAP),
        .BLANK     (BLANK)
    ) u_lft (
        .clk     (clk),
        .rst     (rst),
        .cnt     (cnt),
        .duty    (lft_duty),
        .kill    (gate_kill),
        .hi      (lft_hi),
        .lo      (lft_lo),
        .qual_win(lft_win)
    );

    pwm_chan #(
        .NONOVERLAP(NONOVERLAP),
        .BLANK     (BLANK)
    ) u_rght (
        .clk     (clk),
        .rst     (rst),
        .cnt     (cnt),
        .duty    (rght_duty),
        .kill    (gate_kill),
        .hi      (rght_hi),
        .lo      (rght_lo),
        .qual_win(rght_win)
    );

    assign ovr_qual = ovr_i & (lft_win | rght_win);

    // A sample on the last count still belongs to the period being judged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_faulty <= 1'b0;
            fault_cnt     <= '0;
            ovr_flt       <= 1'b0;
        end else begin
            if (cnt_end) begin
                period_faulty <= 1'b0;
                if (period_faulty | ovr_qual) begin
                    if (fault_cnt < FC_LIM) begin
                        fault_cnt <= fault_cnt + FC_W'(1);
                    end
                end else begin
                    fault_cnt <= '0;
                end
            end else if (ovr_qual) begin
                period_faulty <= 1'b1;
            end
            if (fault_cnt >= FC_LIM) begin
                ovr_flt <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: gate windows, saturation, duty timing,
// dead-time, enable gating, over-current blanking/trip and async reset.
module tb_mtr_drv;

    logic clk = 1'b0;
    logic rst;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic en;
    logic ovr_i;
    logic lft_hi, lft_lo, rght_hi, rght_lo, pwm_synch, ovr_flt;

    logic [11:0] lft_spd2;
    logic [11:0] rght_spd2;
    logic ovr_i2;
    logic lft_hi2, lft_lo2, rght_hi2, rght_lo2, pwm_synch2, ovr_flt2;

    int tb_cnt;
    int n_cmp = 0;
    int n_fail = 0;

    // Per channel (0=lft, 1=rght, 2=lft wide dead-time, 3=rght wide dead-time):
    // hi_n, hi_first, hi_last, lo_n, lo_first, lo_last in terms of previous cnt.
    int res [4][6];
    int overlap_n;
    int synch_n;
    int synch_pos;
    string fname [6] = '{"hi_n", "hi_first", "hi_last", "lo_n", "lo_first", "lo_last"};

    always #5 clk = ~clk;

    mtr_drv dut (
        .clk      (clk),
        .rst      (rst),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .en       (en),
        .ovr_i    (ovr_i),
        .lft_hi   (lft_hi),
        .lft_lo   (lft_lo),
        .rght_hi  (rght_hi),
        .rght_lo  (rght_lo),
        .pwm_synch(pwm_synch),
        .ovr_flt  (ovr_flt)
    );

    mtr_drv #(.NONOVERLAP(70)) dut_wide (
        .clk      (clk),
        .rst      (rst),
        .lft_spd  (lft_spd2),
        .rght_spd (rght_spd2),
        .en       (en),
        .ovr_i    (ovr_i2),
        .lft_hi   (lft_hi2),
        .lft_lo   (lft_lo2),
        .rght_hi  (rght_hi2),
        .rght_lo  (rght_lo2),
        .pwm_synch(pwm_synch2),
        .ovr_flt  (ovr_flt2)
    );

    // Reference period counter, equal to the DUT count after each rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 0;
        else     tb_cnt <= (tb_cnt + 1) % 2048;
    end

    task automatic wait_cnt(input int target);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tb_cnt != target && k < 4200);
        if (tb_cnt != target) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL wait_cnt: cnt %0d, required %0d", tb_cnt, target);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r, input logic e);
        lft_spd  = l;
        rght_spd = r;
        en       = e;
    endtask

    task automatic pulse_ovr(input int pos, input int periods);
        for (int p = 0; p < periods; p++) begin
            wait_cnt(pos);
            ovr_i = 1'b1;
            @(negedge clk);
            ovr_i = 1'b0;
        end
    endtask

    // Samples one whole period: gate states for previous cnt 0..2047.
    task automatic measure_period();
        logic [3:0] h;
        logic [3:0] l;
        int prev;
        for (int c = 0; c < 4; c++) begin
            res[c] = '{0, -1, -1, 0, -1, -1};
        end
        overlap_n = 0;
        synch_n   = 0;
        synch_pos = -1;
        wait_cnt(1);
        for (int s = 0; s < 2048; s++) begin
            if (s > 0) @(negedge clk);
            prev = (tb_cnt + 2047) % 2048;
            h = {rght_hi2, lft_hi2, rght_hi, lft_hi};
            l = {rght_lo2, lft_lo2, rght_lo, lft_lo};
            for (int c = 0; c < 4; c++) begin
                if (h[c] === 1'b1) begin
                    res[c][0]++;
                    if (res[c][1] < 0) res[c][1] = prev;
                    res[c][2] = prev;
                end
                if (l[c] === 1'b1) begin
                    res[c][3]++;
                    if (res[c][4] < 0) res[c][4] = prev;
                    res[c][5] = prev;
                end
            end
            if ((h & l) != 4'b0) overlap_n++;
            if (pwm_synch === 1'b1) begin
                synch_n++;
                synch_pos = tb_cnt;
            end
        end
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b0;
        applyStimulus(12'd0, 12'd0, 1'b0);
        ovr_i     = 1'b0;
        ovr_i2    = 1'b0;
        lft_spd2  = 12'hC40;
        rght_spd2 = 12'd0;
        #1 rst = 1'b1;
        #2;
        got = {lft_hi, lft_lo, rght_hi, rght_lo, pwm_synch, ovr_flt,
               lft_hi2, lft_lo2, rght_hi2, rght_lo2, pwm_synch2, ovr_flt2};
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (got[i] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL reset output bit %0d: got %b, required 0", i, got[i]);
            end
        end
        @(negedge clk);
        en  = 1'b1;
        rst = 1'b0;
    endtask

    task automatic test_zero_speed();
        int exp_tab [2][6];
        exp_tab = '{'{992, 32, 1023, 992, 1056, 2047}, '{992, 32, 1023, 992, 1056, 2047}};
        measure_period();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (res[c][k] !== exp_tab[c][k]) begin
                    n_fail++;
                    $display("[TB] FAIL zero ch%0d %s: got %0d, required %0d", c, fname[k], res[c][k], exp_tab[c][k]);
                end
            end
        end
        n_cmp++;
        if (overlap_n !== 0) begin
            n_fail++;
            $display("[TB] FAIL zero overlap: got %0d, required 0", overlap_n);
        end
        n_cmp++;
        if (synch_n !== 1) begin
            n_fail++;
            $display("[TB] FAIL zero synch count: got %0d, required 1", synch_n);
        end
        n_cmp++;
        if (synch_pos !== 1) begin
            n_fail++;
            $display("[TB] FAIL zero synch position: got %0d, required 1", synch_pos);
        end
    endtask

    task automatic test_saturation();
        int exp_tab [2][6];
        exp_tab = '{'{1952, 32, 1983, 32, 2016, 2047}, '{32, 32, 63, 1952, 96, 2047}};
        applyStimulus(12'h7FF, 12'h800, 1'b1);
        wait_cnt(2000);
        measure_period();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (res[c][k] !== exp_tab[c][k]) begin
                    n_fail++;
                    $display("[TB] FAIL sat ch%0d %s: got %0d, required %0d", c, fname[k], res[c][k], exp_tab[c][k]);
                end
            end
        end
        n_cmp++;
        if (overlap_n !== 0) begin
            n_fail++;
            $display("[TB] FAIL sat overlap: got %0d, required 0", overlap_n);
        end
    endtask

    task automatic test_mid_change();
        int exp_tab [2][6];
        exp_tab = '{'{1292, 32, 1323, 692, 1356, 2047}, '{992, 32, 1023, 992, 1056, 2047}};
        applyStimulus(12'd0, 12'd0, 1'b1);
        wait_cnt(2047);
        wait_cnt(500);
        lft_spd = 12'd300;
        wait_cnt(1024);
        n_cmp++;
        if (lft_hi !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid hi at prev 1023: got %b, required 1", lft_hi);
        end
        wait_cnt(1025);
        n_cmp++;
        if (lft_hi !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid hi at prev 1024: got %b, required 0", lft_hi);
        end
        measure_period();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (res[c][k] !== exp_tab[c][k]) begin
                    n_fail++;
                    $display("[TB] FAIL mid ch%0d %s: got %0d, required %0d", c, fname[k], res[c][k], exp_tab[c][k]);
                end
            end
        end
    endtask

    task automatic test_nonoverlap();
        int exp_tab [2][6];
        exp_tab = '{'{0, -1, -1, 1914, 134, 2047}, '{954, 70, 1023, 954, 1094, 2047}};
        measure_period();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (res[c + 2][k] !== exp_tab[c][k]) begin
                    n_fail++;
                    $display("[TB] FAIL wide ch%0d %s: got %0d, required %0d", c + 2, fname[k], res[c + 2][k], exp_tab[c][k]);
                end
            end
        end
        n_cmp++;
        if (overlap_n !== 0) begin
            n_fail++;
            $display("[TB] FAIL wide overlap: got %0d, required 0", overlap_n);
        end
    endtask

    task automatic test_enable();
        en = 1'b0;
        measure_period();
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (res[c][0] !== 0 || res[c][3] !== 0) begin
                n_fail++;
                $display("[TB] FAIL disabled ch%0d gates: got hi %0d lo %0d, required 0 0", c, res[c][0], res[c][3]);
            end
        end
        n_cmp++;
        if (synch_n !== 1) begin
            n_fail++;
            $display("[TB] FAIL disabled synch count: got %0d, required 1", synch_n);
        end
        wait_cnt(500);
        n_cmp++;
        if (lft_hi !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL disabled hi at 500: got %b, required 0", lft_hi);
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({lft_hi, lft_lo, rght_hi, rght_lo} !== 4'b1010) begin
            n_fail++;
            $display("[TB] FAIL enable resume gates: got %b, required 1010", {lft_hi, lft_lo, rght_hi, rght_lo});
        end
    endtask

    task automatic test_blanking();
        pulse_ovr(80, 2);
        pulse_ovr(96, 2);
        wait_cnt(2047);
        wait_cnt(2);
        n_cmp++;
        if (ovr_flt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL blanked pulses: got ovr_flt %b, required 0", ovr_flt);
        end
    endtask

    task automatic test_three_then_clean();
        pulse_ovr(200, 3);
        wait_cnt(2047);
        wait_cnt(2047);
        pulse_ovr(200, 3);
        wait_cnt(2047);
        wait_cnt(3);
        n_cmp++;
        if (ovr_flt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL three then clean: got ovr_flt %b, required 0", ovr_flt);
        end
    endtask

    task automatic test_fault_trip();
        wait_cnt(2047);
        pulse_ovr(200, 4);
        wait_cnt(2047);
        n_cmp++;
        if (ovr_flt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL trip before 4th end: got %b, required 0", ovr_flt);
        end
        wait_cnt(0);
        n_cmp++;
        if (ovr_flt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL trip at wrap: got %b, required 0", ovr_flt);
        end
        wait_cnt(1);
        n_cmp++;
        if (ovr_flt !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL trip set: got %b, required 1", ovr_flt);
        end
        measure_period();
        for (int c = 0; c < 2; c++) begin
            n_cmp++;
            if (res[c][0] !== 0 || res[c][3] !== 0) begin
                n_fail++;
                $display("[TB] FAIL tripped ch%0d gates: got hi %0d lo %0d, required 0 0", c, res[c][0], res[c][3]);
            end
        end
        n_cmp++;
        if (synch_n !== 1) begin
            n_fail++;
            $display("[TB] FAIL tripped synch count: got %0d, required 1", synch_n);
        end
        en = 1'b0;
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ovr_flt !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL fault after en toggle: got %b, required 1", ovr_flt);
        end
    endtask

    task automatic test_reset_mid();
        int exp_tab [2][6];
        exp_tab = '{'{992, 32, 1023, 992, 1056, 2047}, '{954, 70, 1023, 954, 1094, 2047}};
        wait_cnt(1500);
        n_cmp++;
        if (lft_lo2 !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre-reset wide lo: got %b, required 1", lft_lo2);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({lft_hi, lft_lo, rght_hi, rght_lo, pwm_synch, ovr_flt, lft_lo2, rght_lo2} !== 8'b0) begin
            n_fail++;
            $display("[TB] FAIL async reset outputs: got %b, required 00000000",
                     {lft_hi, lft_lo, rght_hi, rght_lo, pwm_synch, ovr_flt, lft_lo2, rght_lo2});
        end
        @(negedge clk);
        rst = 1'b0;
        measure_period();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (res[c * 2][k] !== exp_tab[c][k]) begin
                    n_fail++;
                    $display("[TB] FAIL post-reset ch%0d %s: got %0d, required %0d", c * 2, fname[k], res[c * 2][k], exp_tab[c][k]);
                end
            end
        end
        n_cmp++;
        if (ovr_flt !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL post-reset ovr_flt: got %b, required 0", ovr_flt);
        end
    endtask

    initial begin
        test_reset();
        test_zero_speed();
        test_saturation();
        test_mid_change();
        test_nonoverlap();
        test_enable();
        test_blanking();
        test_three_then_clean();
        test_fault_trip();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
